rv_elastic_buffer: RTL and testbench

Parametrised ready/valid elastic buffer, successor to the two-entry skid slice: DEPTH entries instead of a fixed destination/skid pair, plus an occupancy count, an almost-full flag and a synchronous flush. It sits on any registered ready/valid channel between a producer and a consumer. It cuts every combinational path between the two sides while sustaining one transfer per cycle. It also absorbs bursts of up to DEPTH beats while the consumer stalls.

---
 rtl/rv_pkg.sv | 27 ++
 rtl/rv_ptr_wrap.sv | 44 ++++
 rtl/rv_elastic_buffer.sv | 108 ++++++++++
 tb/tb_rv_elastic_buffer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// ============================================================================
// Module      : rv_pkg
// Description : Shared sizing helpers and parameter legality test for the
//               ready/valid elastic buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic bit params_legal(input int depth, input int afull_thresh);
    return (depth >= 2) && (afull_thresh >= 1) && (afull_thresh <= depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_ptr_wrap.sv
// ============================================================================
// Module      : rv_ptr_wrap
// Description : Circular index 0..DEPTH-1 with advance enable and synchronous
//               clear; wraps correctly for non-power-of-two depths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_ptr_wrap #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             adv,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (adv) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

`default_nettype wire

// File: rtl/rv_elastic_buffer.sv
// ============================================================================
// Module      : rv_elastic_buffer
// Description : DEPTH-entry ready/valid elastic buffer with registered
//               handshake outputs, occupancy count, almost-full and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_elastic_buffer
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      valid_in,
  input  logic [DATA_WIDTH-1:0]     data_in,
  output logic                      ready_out,
  output logic                      valid_out,
  output logic [DATA_WIDTH-1:0]     data_out,
  input  logic                      ready_in,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      almost_full
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = ptr_w(DEPTH);

  if (!params_legal(DEPTH, AFULL_THRESH)) begin : g_param_check
    $error("rv_elastic_buffer: illegal DEPTH=%0d / AFULL_THRESH=%0d", DEPTH, AFULL_THRESH);
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic                  afull_q, afull_d;
  logic                  push;
  logic                  pop;

  // Handshake flags are derived from the next count so they are pure flop outputs.
  always_comb begin
    push    = valid_in & ready_q;
    pop     = valid_q & ready_in;
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    ready_d = (count_d < CNT_W'(DEPTH));
    valid_d = (count_d != '0);
    afull_d = (count_d >= CNT_W'(AFULL_THRESH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      afull_q <= 1'b0;
    end else begin
      count_q <= count_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      afull_q <= afull_d;
    end
  end

  // Storage is deliberately left out of reset; valid_out gates what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr] <= data_in;
    end
  end

  rv_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .adv     (push),
    .ptr     (wr_ptr)
  );

  rv_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .adv     (pop),
    .ptr     (rd_ptr)
  );

  assign ready_out   = ready_q;
  assign valid_out   = valid_q;
  assign count       = count_q;
  assign almost_full = afull_q;
  assign data_out    = valid_q ? mem_q[rd_ptr] : '0;

endmodule

`default_nettype wire

// File: tb/tb_rv_elastic_buffer.sv
// ============================================================================
// Module      : tb_rv_elastic_buffer
// Description : Scoreboard bench for rv_elastic_buffer at DEPTH 4, 3, 5 and 2,
//               plus a two-entry reference model for the DEPTH=2 instance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_elastic_buffer;

  localparam int NI = 4;
  // Instance k uses DEP[k] / THR[k]: 0:(4,3) 1:(3,2) 2:(5,4) 3:(2,1)
  localparam logic [NI-1:0][3:0] DEP = {4'd2, 4'd5, 4'd3, 4'd4};
  localparam logic [NI-1:0][3:0] THR = {4'd1, 4'd4, 4'd2, 4'd3};

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       vin  [NI];
  logic       rin  [NI];
  logic       fl   [NI];
  logic [7:0] din  [NI];
  logic       ro   [NI];
  logic       vo   [NI];
  logic       af   [NI];
  logic [7:0] dout [NI];
  logic [3:0] cnt  [NI];

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] fill_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [3:0] fill_c [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
  logic [3:0] fill_af = 4'b1100;
  logic [3:0] fill_ro = 4'b0111;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D  = int'(DEP[g]);
    localparam int CW = $clog2(D + 1);
    logic [CW-1:0] c_w;
    logic [7:0]    exp_q [$];

    rv_elastic_buffer #(
      .DATA_WIDTH   (8),
      .DEPTH        (D),
      .AFULL_THRESH (int'(THR[g]))
    ) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush       (fl[g]),
      .valid_in    (vin[g]),
      .data_in     (din[g]),
      .ready_out   (ro[g]),
      .valid_out   (vo[g]),
      .data_out    (dout[g]),
      .ready_in    (rin[g]),
      .count       (c_w),
      .almost_full (af[g])
    );

    assign cnt[g] = 4'(c_w);

    // Output side pops before input side pushes: a same-cycle pop drains the old head.
    always @(negedge clk) begin
      if (!reset_n || fl[g]) begin
        exp_q.delete();
      end else begin
        if (vo[g] && rin[g]) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL beat_unexpected inst%0d: got 0x%0h expected no beat", g, dout[g]);
          end else begin
            check($sformatf("beat_data_inst%0d", g), 32'(dout[g]), 32'(exp_q.pop_front()));
          end
        end
        if (vin[g] && ro[g]) exp_q.push_back(din[g]);
      end
    end
  end

  // Two-entry reference model for the DEPTH=2 instance
  logic [7:0] mq [$];
  logic       m_rdy = 1'b0;
  logic       m_vld = 1'b0;
  logic       eq_en = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      mq.delete();
      m_rdy = 1'b0;
      m_vld = 1'b0;
    end else begin
      if (eq_en) begin
        check("eq_valid_out", 32'(vo[3]), 32'(m_vld));
        check("eq_ready_out", 32'(ro[3]), 32'(m_rdy));
        check("eq_data_out", 32'(dout[3]), m_vld ? 32'(mq[0]) : 32'h0);
      end
      if (m_vld && rin[3]) void'(mq.pop_front());
      if (m_rdy && vin[3]) mq.push_back(din[3]);
      m_rdy = (mq.size() < 2);
      m_vld = (mq.size() > 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent;
    logic acc;
    for (int i = 0; i < NI; i++) begin
      vin[i] = 1'b0; rin[i] = 1'b0; fl[i] = 1'b0; din[i] = 8'h00;
    end

    // Reset state
    repeat (2) tick();
    check("rst_ready_out", 32'(ro[0]), 32'd0);
    check("rst_valid_out", 32'(vo[0]), 32'd0);
    check("rst_count", 32'(cnt[0]), 32'd0);
    check("rst_almost_full", 32'(af[0]), 32'd0);
    check("rst_data_out", 32'(dout[0]), 32'd0);
    reset_n = 1'b1;
    check("rel_ready_before_edge", 32'(ro[0]), 32'd0);
    tick();
    check("rel_ready_after_edge", 32'(ro[0]), 32'd1);
    check("rel_count", 32'(cnt[0]), 32'd0);

    // Fill with a stall, DEPTH=4, AFULL_THRESH=3
    for (int k = 0; k < 4; k++) begin
      vin[0] = 1'b1; din[0] = fill_d[k];
      tick();
      check($sformatf("fill_count_%0d", k), 32'(cnt[0]), 32'(fill_c[k]));
      check($sformatf("fill_afull_%0d", k), 32'(af[0]), 32'(fill_af[k]));
      check($sformatf("fill_ready_%0d", k), 32'(ro[0]), 32'(fill_ro[k]));
      check($sformatf("fill_head_%0d", k), 32'(dout[0]), 32'h11);
    end
    din[0] = 8'h55;
    tick();
    check("full_hold_count", 32'(cnt[0]), 32'd4);
    check("full_hold_ready", 32'(ro[0]), 32'd0);
    vin[0] = 1'b0;
    rin[0] = 1'b1;
    tick();
    check("drain_ready_after_first_pop", 32'(ro[0]), 32'd1);
    check("drain_count_1", 32'(cnt[0]), 32'd3);
    check("drain_afull_1", 32'(af[0]), 32'd1);
    check("drain_head_1", 32'(dout[0]), 32'h22);
    tick();
    check("drain_afull_2", 32'(af[0]), 32'd0);
    repeat (2) tick();
    check("drain_count_end", 32'(cnt[0]), 32'd0);
    check("drain_valid_end", 32'(vo[0]), 32'd0);
    check("drain_data_gated", 32'(dout[0]), 32'd0);
    check("drain_sb_empty", 32'(g_dut[0].exp_q.size()), 32'd0);
    rin[0] = 1'b0;

    // Reset mid-burst
    for (int k = 0; k < 3; k++) begin
      vin[0] = 1'b1; din[0] = 8'hA1 + 8'(k);
      tick();
    end
    vin[0] = 1'b0;
    check("burst_count", 32'(cnt[0]), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_ready", 32'(ro[0]), 32'd0);
    check("async_rst_valid", 32'(vo[0]), 32'd0);
    check("async_rst_count", 32'(cnt[0]), 32'd0);
    check("async_rst_afull", 32'(af[0]), 32'd0);
    check("async_rst_data", 32'(dout[0]), 32'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    check("burst_rel_ready_before_edge", 32'(ro[0]), 32'd0);
    tick();
    check("burst_rel_ready", 32'(ro[0]), 32'd1);
    check("burst_rel_count", 32'(cnt[0]), 32'd0);
    check("burst_rel_valid", 32'(vo[0]), 32'd0);

    // Flush collision at count=2
    for (int k = 0; k < 2; k++) begin
      vin[0] = 1'b1; din[0] = 8'h01 + 8'(k);
      tick();
    end
    vin[0] = 1'b0;
    check("pre_flush_count", 32'(cnt[0]), 32'd2);
    fl[0] = 1'b1; vin[0] = 1'b1; din[0] = 8'hAA; rin[0] = 1'b1;
    tick();
    fl[0] = 1'b0; vin[0] = 1'b0; rin[0] = 1'b0;
    check("flush_count", 32'(cnt[0]), 32'd0);
    check("flush_valid", 32'(vo[0]), 32'd0);
    check("flush_ready", 32'(ro[0]), 32'd1);
    check("flush_data", 32'(dout[0]), 32'd0);
    vin[0] = 1'b1; din[0] = 8'hBB;
    tick();
    vin[0] = 1'b0;
    check("post_flush_head", 32'(dout[0]), 32'hBB);
    rin[0] = 1'b1;
    tick();
    rin[0] = 1'b0;
    check("post_flush_count", 32'(cnt[0]), 32'd0);
    check("post_flush_sb_empty", 32'(g_dut[0].exp_q.size()), 32'd0);

    // Full-rate streaming, DEPTH=3
    vin[1] = 1'b1; rin[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din[1] = 8'(i);
      tick();
      check($sformatf("stream_count_%0d", i), 32'(cnt[1]), 32'd1);
      check($sformatf("stream_latency_%0d", i), 32'(dout[1]), 32'(i));
    end
    vin[1] = 1'b0;
    tick();
    rin[1] = 1'b0;
    check("stream_end_count", 32'(cnt[1]), 32'd0);
    check("stream_end_valid", 32'(vo[1]), 32'd0);
    check("stream_sb_empty", 32'(g_dut[1].exp_q.size()), 32'd0);

    // Non-power-of-two wrap, DEPTH=5
    sent = 0;
    for (int cyc = 0; cyc < 400 && sent < 12; cyc++) begin
      din[2] = 8'hC0 + 8'(sent);
      vin[2] = 1'($urandom_range(0, 1));
      rin[2] = 1'($urandom_range(0, 1));
      acc = vin[2] && ro[2];
      tick();
      if (acc) sent++;
    end
    check("wrap_beats_sent", 32'(sent), 32'd12);
    vin[2] = 1'b0; rin[2] = 1'b1;
    for (int cyc = 0; cyc < 20 && vo[2]; cyc++) tick();
    rin[2] = 1'b0;
    check("wrap_end_count", 32'(cnt[2]), 32'd0);
    check("wrap_end_valid", 32'(vo[2]), 32'd0);
    check("wrap_sb_empty", 32'(g_dut[2].exp_q.size()), 32'd0);

    // DEPTH=2 cycle equivalence against the two-entry model
    eq_en = 1'b1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      vin[3] = 1'($urandom_range(0, 1));
      rin[3] = 1'($urandom_range(0, 1));
      din[3] = 8'($urandom_range(0, 255));
      tick();
    end
    vin[3] = 1'b0; rin[3] = 1'b1;
    repeat (3) tick();
    eq_en = 1'b0;
    rin[3] = 1'b0;
    check("eq_end_count", 32'(cnt[3]), 32'd0);
    check("eq_sb_empty", 32'(g_dut[3].exp_q.size()), 32'd0);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
